traffic_conflict_monitor: RTL
=============================

TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 2, consecutive equal raw samples before a filtered lamp changes (range 1..15).
REQ-002 Parameter MIN_GREEN, default 4, minimum filtered green duration in cycles per road (range 1..15).
REQ-003 Parameter MAX_DARK, default 8, maximum cycles a road may show no lamp (range 1..15).
REQ-004 Parameter ARM_CYC, default 4, cycles spent in ARMING before checks are enabled (range 1..15).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 red_MR1, yellow_MR1, green_MR1  input  1 each  raw lamp drives, main road 1.
REQ-008 red_MR2, yellow_MR2, green_MR2  input  1 each  raw lamp drives, main road 2.
REQ-009 red_MR3, yellow_MR3, green_MR3  input  1 each  raw lamp drives, main road 3.
REQ-010 fault_clr  input  1  single-cycle request to leave FAULT.
REQ-011 fault_o  output  1  latched fault indicator.
REQ-012 fault_code  output  3  0 none, 1 conflict, 2 multi-lamp, 3 dark, 4 short-green.
REQ-013 fault_road  output  2  offending road 1..3; 0 for conflict or no fault.
REQ-014 flash_req  output  1  request to controller to force all-red flash.
REQ-015 armed  output  1  high in MONITOR state only.

Function
REQ-016 Nine per-lamp filters: a filtered lamp takes a new raw value at the edge where that value has been sampled DEBOUNCE_CYC consecutive edges; all checks use filtered values only.
REQ-017 FSM states ARMING, MONITOR, FAULT; ARMING->MONITOR after ARM_CYC cycles; MONITOR->FAULT on any detected fault; FAULT->ARMING on fault_clr when no fault condition is present that cycle; otherwise FAULT holds.
REQ-018 Conflict: two or more filtered greens high in the same cycle.
REQ-019 Multi-lamp: any road with more than one filtered lamp high.
REQ-020 Dark: per-road 4-bit counter increments while all three filtered lamps are low, clears otherwise, saturates; fault when it reaches MAX_DARK.
REQ-021 Short-green: per-road counter increments while filtered green is high, saturates at MIN_GREEN; fault when green falls with counter < MIN_GREEN; counter clears when green is low.
REQ-022 On ARMING->MONITOR exit, green counters preset to MIN_GREEN and dark counters cleared, so pre-existing greens never flag short-green.
REQ-023 Detection is combinational on filtered values; fault_o, fault_code, fault_road register at the next edge: raw violation -> fault_o high DEBOUNCE_CYC+1 edges later.
REQ-024 Simultaneous faults: priority conflict > multi-lamp > dark > short-green; among roads, lowest road number wins.
REQ-025 In FAULT, code and road hold the first fault; further faults ignored; flash_req = 1.
REQ-026 Checks and fault capture disabled in ARMING and FAULT; filters run in every state.
REQ-027 fault_clr outside FAULT has no effect; fault_clr leaving FAULT clears fault_o, fault_code, fault_road and flash_req at the same edge.

Reset
REQ-028 reset forces state ARMING, arming counter 0, all lamp-check counters 0, filter counters 0.
REQ-029 Filtered reds reset to 1, filtered yellows/greens to 0.
REQ-030 Reset values: fault_o 0, fault_code 0, fault_road 0, flash_req 0, armed 0; reset asserted mid-FAULT discards the latched fault.

Configuration
REQ-031 Macro TCM_DARK_CHECK_EN defined: dark check (REQ-020) compiled in; undefined: dark counters absent, code 3 never produced, all else unchanged.

Structure
REQ-032 Package tcm_pkg holds the FSM state enum, the fault-code enum and the 3-bit/2-bit width constants.
REQ-033 Sub-module tcm_debounce (one lamp, DEBOUNCE_CYC parameter) instantiated nine times.

Verification
REQ-034 Reset, 4 idle cycles with all reds high -> armed rises at edge 5, fault_o stays 0.
REQ-035 Armed, green_MR1 and green_MR2 raised together -> fault_o=1, code=1, road=0, flash_req=1 three edges later.
REQ-036 Armed, green_MR2 high for 2 cycles then low (MIN_GREEN=4) -> code=4, road=2.
REQ-037 Armed, red_MR3 low with no lamp on road 3 for 10 cycles -> code=3, road=3 (macro defined); fault_o stays 0 (macro undefined).
REQ-038 In FAULT, fault_clr while conflict persists -> stays FAULT; fault_clr after conflict clears -> ARMING, all fault outputs 0 next cycle.
REQ-039 One-cycle glitch on green_MR3 with DEBOUNCE_CYC=2 -> no fault; reset asserted in FAULT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/tcm_pkg.sv
// rtl/tcm_pkg.sv - shared types and widths for the traffic conflict monitor
package tcm_pkg;

    localparam int NUM_ROADS    = 3;
    localparam int FAULT_CODE_W = 3;
    localparam int FAULT_ROAD_W = 2;

    typedef enum logic [1:0] {
        ST_ARMING  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } tcm_state_e;

    typedef enum logic [FAULT_CODE_W-1:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_MULTI    = 3'd2,
        FC_DARK     = 3'd3,
        FC_SHORT    = 3'd4
    } tcm_fault_e;

    // Road number (1..NUM_ROADS) of the lowest set bit, 0 when none is set.
    function automatic logic [FAULT_ROAD_W-1:0] first_road(input logic [NUM_ROADS-1:0] hits);
        logic [FAULT_ROAD_W-1:0] road;
        road = '0;
        for (int r = NUM_ROADS - 1; r >= 0; r--) begin
            if (hits[r]) begin
                road = FAULT_ROAD_W'(r + 1);
            end
        end
        return road;
    endfunction

endpackage

// File: rtl/tcm_debounce.sv
// rtl/tcm_debounce.sv - single lamp filter, follows raw input once it is stable
// Ports: clk, reset (sync, active-high), raw_i raw lamp drive, filt_o filtered lamp.
// filt_o takes a new raw value at the edge where that value has been sampled
// DEBOUNCE_CYC consecutive edges; RESET_VAL is the filtered value after reset.
module tcm_debounce #(
    parameter int   DEBOUNCE_CYC = 2,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);

    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the filtered value;
    // any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = 4'd0;
        if (raw_i != filt_q) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_CYC)) begin
                filt_d = raw_i;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= RESET_VAL;
            cnt_q  <= 4'd0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - three-road lamp conflict / sanity monitor
// Ports: clk, reset (sync, active-high); red/yellow/green_MR1..3 raw lamp drives;
//        fault_clr request to leave FAULT; fault_o latched fault; fault_code
//        (0 none, 1 conflict, 2 multi-lamp, 3 dark, 4 short-green); fault_road
//        (1..3, 0 for conflict/none); flash_req all-red flash request; armed
//        high while monitoring.
// Build option: TCM_DARK_CHECK_EN compiles in the dark-road check (code 3).
module traffic_conflict_monitor
    import tcm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_DARK     = 8,
    parameter int ARM_CYC      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    red_MR1,
    input  logic                    yellow_MR1,
    input  logic                    green_MR1,
    input  logic                    red_MR2,
    input  logic                    yellow_MR2,
    input  logic                    green_MR2,
    input  logic                    red_MR3,
    input  logic                    yellow_MR3,
    input  logic                    green_MR3,
    input  logic                    fault_clr,
    output logic                    fault_o,
    output logic [FAULT_CODE_W-1:0] fault_code,
    output logic [FAULT_ROAD_W-1:0] fault_road,
    output logic                    flash_req,
    output logic                    armed
);

    localparam logic [3:0] MIN_GREEN_C = 4'(MIN_GREEN);
    localparam logic [3:0] ARM_CYC_C   = 4'(ARM_CYC);

    // A mis-configured monitor never leaves ARMING, so it never claims to be watching.
    localparam bit CFG_OK = (DEBOUNCE_CYC >= 1) && (DEBOUNCE_CYC <= 15) &&
                            (MIN_GREEN >= 1) && (MIN_GREEN <= 15) &&
                            (MAX_DARK >= 1) && (MAX_DARK <= 15) &&
                            (ARM_CYC >= 1) && (ARM_CYC <= 15);

    logic [NUM_ROADS-1:0] red_raw, yel_raw, grn_raw;
    logic [NUM_ROADS-1:0] red_f, yel_f, grn_f;

    assign red_raw = {red_MR3, red_MR2, red_MR1};
    assign yel_raw = {yellow_MR3, yellow_MR2, yellow_MR1};
    assign grn_raw = {green_MR3, green_MR2, green_MR1};

    for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
        tcm_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b1)) u_red (
            .clk(clk), .reset(reset), .raw_i(red_raw[r]), .filt_o(red_f[r])
        );
        tcm_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b0)) u_yel (
            .clk(clk), .reset(reset), .raw_i(yel_raw[r]), .filt_o(yel_f[r])
        );
        tcm_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b0)) u_grn (
            .clk(clk), .reset(reset), .raw_i(grn_raw[r]), .filt_o(grn_f[r])
        );
    end

    tcm_state_e                 state_q, state_d;
    logic [3:0]                 arm_cnt_q, arm_cnt_d;
    logic                       fault_q, fault_d;
    tcm_fault_e                 code_q, code_d;
    logic [FAULT_ROAD_W-1:0]    road_q, road_d;
    logic [NUM_ROADS-1:0][3:0]  gcnt_q, gcnt_d;

    logic                       arm_exit;
    logic                       conflict;
    logic [NUM_ROADS-1:0]       multi, dark_flt, short_g;
    logic                       any_fault;
    tcm_fault_e                 sel_code;
    logic [FAULT_ROAD_W-1:0]    sel_road;

    assign arm_exit = CFG_OK && (state_q == ST_ARMING) && (arm_cnt_q == ARM_CYC_C);

`ifdef TCM_DARK_CHECK_EN
    localparam logic [3:0] MAX_DARK_C = 4'(MAX_DARK);

    logic [NUM_ROADS-1:0][3:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d   = dcnt_q;
        dark_flt = '0;
        for (int r = 0; r < NUM_ROADS; r++) begin
            dark_flt[r] = (dcnt_q[r] >= MAX_DARK_C);
            if (red_f[r] || yel_f[r] || grn_f[r]) begin
                dcnt_d[r] = 4'd0;
            end else if (dcnt_q[r] != 4'hf) begin
                dcnt_d[r] = dcnt_q[r] + 4'd1;
            end
            if (arm_exit) begin
                dcnt_d[r] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end
`else
    assign dark_flt = '0;
`endif

    // Fault detection and green-duration tracking on filtered lamps.
    always_comb begin
        conflict = (grn_f[0] & grn_f[1]) | (grn_f[0] & grn_f[2]) | (grn_f[1] & grn_f[2]);
        multi    = (red_f & yel_f) | (red_f & grn_f) | (yel_f & grn_f);
        short_g  = '0;
        gcnt_d   = gcnt_q;
        for (int r = 0; r < NUM_ROADS; r++) begin
            // The counter is only non-zero with green low in the cycle right after green fell.
            short_g[r] = !grn_f[r] && (gcnt_q[r] != 4'd0) && (gcnt_q[r] < MIN_GREEN_C);
            if (!grn_f[r]) begin
                gcnt_d[r] = 4'd0;
            end else if (gcnt_q[r] < MIN_GREEN_C) begin
                gcnt_d[r] = gcnt_q[r] + 4'd1;
            end
            // Greens already running when monitoring starts count as long enough.
            if (arm_exit) begin
                gcnt_d[r] = MIN_GREEN_C;
            end
        end

        any_fault = conflict || (|multi) || (|dark_flt) || (|short_g);

        sel_code = FC_NONE;
        sel_road = '0;
        if (conflict) begin
            sel_code = FC_CONFLICT;
        end else if (|multi) begin
            sel_code = FC_MULTI;
            sel_road = first_road(multi);
        end else if (|dark_flt) begin
            sel_code = FC_DARK;
            sel_road = first_road(dark_flt);
        end else if (|short_g) begin
            sel_code = FC_SHORT;
            sel_road = first_road(short_g);
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        fault_d   = fault_q;
        code_d    = code_q;
        road_d    = road_q;
        case (state_q)
            ST_ARMING: begin
                if (arm_exit) begin
                    state_d = ST_MONITOR;
                end else if (arm_cnt_q != 4'hf) begin
                    arm_cnt_d = arm_cnt_q + 4'd1;
                end
            end
            ST_MONITOR: begin
                if (any_fault) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = sel_code;
                    road_d  = sel_road;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !any_fault) begin
                    state_d   = ST_ARMING;
                    arm_cnt_d = 4'd0;
                    fault_d   = 1'b0;
                    code_d    = FC_NONE;
                    road_d    = '0;
                end
            end
            default: begin
                state_d   = ST_ARMING;
                arm_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ARMING;
            arm_cnt_q <= 4'd0;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
            road_q    <= '0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            road_q    <= road_d;
            gcnt_q    <= gcnt_d;
        end
    end

    assign fault_o    = fault_q;
    assign fault_code = code_q;
    assign fault_road = road_q;
    assign flash_req  = fault_q;
    assign armed      = (state_q == ST_MONITOR);

endmodule
